// File: rtl/up_axi_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up_axi_master_pkg : shared types and constants for the up_* -> AXI4-Lite   |
// | initiator.                                                   Rev 1.0       |
// +----------------------------------------------------------------------------+
package up_axi_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } chan_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

  // EXOKAY is folded into OKAY; only SLVERR/DECERR report an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/up_axi_master_tmo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up_axi_master_tmo : clear/enable response timeout counter, terminal pulse  |
// | on the TIMEOUT_CYCLES-th enabled cycle.                      Rev 1.0       |
// +----------------------------------------------------------------------------+
module up_axi_master_tmo #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = en_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/up_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | up_axi_master : up_* single-word register requests to AXI4-Lite master,    |
// | independent write/read engines, one outstanding each.        Rev 1.0       |
// +----------------------------------------------------------------------------+
module up_axi_master
  import up_axi_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      up_wreq,
  input  logic [AXI_ADDR_WIDTH-3:0] up_waddr,
  input  logic [31:0]               up_wdata,
  output logic                      up_wack,
  output logic                      up_werr,
  input  logic                      up_rreq,
  input  logic [AXI_ADDR_WIDTH-3:0] up_raddr,
  output logic [31:0]               up_rdata,
  output logic                      up_rack,
  output logic                      up_rerr,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  chan_state_t               wstate_q, wstate_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      wack_q, wack_d;
  logic                      werr_q, werr_d;

  chan_state_t               rstate_q, rstate_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                      arvalid_q, arvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      rack_q, rack_d;
  logic                      rerr_q, rerr_d;

  logic                      w_wr_tmo;
  logic                      w_rd_tmo;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      up_axi_master_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wstate_q != RESP),
        .en_i     (wstate_q == RESP),
        .expire_o (w_wr_tmo)
      );
      up_axi_master_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (rstate_q != RESP),
        .en_i     (rstate_q == RESP),
        .expire_o (w_rd_tmo)
      );
    end else begin : g_no_tmo
      assign w_wr_tmo = 1'b0;
      assign w_rd_tmo = 1'b0;
    end
  endgenerate

  // Write engine: AW and W retire independently; RESP waits for both.
  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wack_d    = 1'b0;
    werr_d    = 1'b0;
    case (wstate_q)
      IDLE: begin
        if (up_wreq) begin
          awaddr_d  = {up_waddr, 2'b00};
          wdata_d   = up_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wstate_d  = ADDR;
        end
      end
      ADDR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    wstate_d  = RESP;
      end
      RESP: begin
        if (m_axi_bvalid) begin
          wack_d   = 1'b1;
          werr_d   = resp_is_err(m_axi_bresp);
          wstate_d = IDLE;
        end else if (w_wr_tmo) begin
          wack_d   = 1'b1;
          werr_d   = 1'b1;
          wstate_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_axi_bvalid) wstate_d = IDLE;
      end
      default: wstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wack_q    <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wack_q    <= wack_d;
      werr_q    <= werr_d;
    end
  end

  // Read engine: same shape with a single address channel.
  always_comb begin
    rstate_d  = rstate_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    rack_d    = 1'b0;
    rerr_d    = 1'b0;
    case (rstate_q)
      IDLE: begin
        if (up_rreq) begin
          araddr_d  = {up_raddr, 2'b00};
          arvalid_d = 1'b1;
          rstate_d  = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rstate_d  = RESP;
        end
      end
      RESP: begin
        if (m_axi_rvalid) begin
          rack_d   = 1'b1;
          rerr_d   = resp_is_err(m_axi_rresp);
          rdata_d  = m_axi_rdata;
          rstate_d = IDLE;
        end else if (w_rd_tmo) begin
          rack_d   = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = TIMEOUT_RDATA;
          rstate_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_axi_rvalid) rstate_d = IDLE;
      end
      default: rstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      rack_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      rack_q    <= rack_d;
      rerr_q    <= rerr_d;
    end
  end

  assign up_wack       = wack_q;
  assign up_werr       = werr_q;
  assign up_rack       = rack_q;
  assign up_rerr       = rerr_q;
  assign up_rdata      = rdata_q;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (wstate_q == RESP) || (wstate_q == DRAIN);

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (rstate_q == RESP) || (rstate_q == DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_up_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_up_axi_master : randomized scoreboard bench with a reactive AXI-Lite    |
// | slave model and a latency/response reference model.          Rev 1.0       |
// +----------------------------------------------------------------------------+
module tb_up_axi_master;

  localparam int TMO = 16;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          aw_wait;
    int          w_wait;
    int          b_delay;
    logic [1:0]  resp;
  } wcfg_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          ar_wait;
    int          r_delay;
    logic [1:0]  resp;
  } rcfg_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up_wreq = 1'b0;
  logic [9:0]  up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack, up_werr;
  logic        up_rreq = 1'b0;
  logic [9:0]  up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack, up_rerr;
  logic [11:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wready  = 1'b0;
  logic [1:0]  m_axi_bresp   = 2'b00;
  logic        m_axi_bvalid  = 1'b0;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata   = '0;
  logic [1:0]  m_axi_rresp   = 2'b00;
  logic        m_axi_rvalid  = 1'b0;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wcfg_t wq[$];
  rcfg_t rq[$];
  exp_t  exp_w[$];
  exp_t  exp_r[$];

  up_axi_master #(.AXI_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata),
    .up_wack(up_wack), .up_werr(up_werr),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_rack(up_rack), .up_rerr(up_rerr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_at_edge <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ack arrives 1 cycle after the response is seen in RESP,
  // or TMO cycles into RESP when the response is later than that.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input int aww,
                          input int ww, input int bd, input logic [1:0] resp);
    wcfg_t c;
    exp_t  e;
    c.addr = a; c.data = d; c.aw_wait = aww; c.w_wait = ww; c.b_delay = bd; c.resp = resp;
    wq.push_back(c);
    e.err  = (bd >= TMO) ? 1'b1 : (resp >= 2'd2);
    e.data = 32'h0;
    e.cyc  = cyc + 2 + ((aww > ww) ? aww : ww) + ((bd >= TMO) ? TMO : bd + 1);
    exp_w.push_back(e);
    up_waddr = a; up_wdata = d; up_wreq = 1'b1;
    @(negedge clk);
    up_wreq = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, input logic [31:0] d, input int arw,
                         input int rd, input logic [1:0] resp);
    rcfg_t c;
    exp_t  e;
    c.addr = a; c.data = d; c.ar_wait = arw; c.r_delay = rd; c.resp = resp;
    rq.push_back(c);
    e.err  = (rd >= TMO) ? 1'b1 : (resp >= 2'd2);
    e.data = (rd >= TMO) ? 32'hDEAD_DEAD : d;
    e.cyc  = cyc + 2 + arw + ((rd >= TMO) ? TMO : rd + 1);
    exp_r.push_back(e);
    up_raddr = a; up_rreq = 1'b1;
    @(negedge clk);
    up_rreq = 1'b0;
  endtask

  task automatic wait_w_idle();
    int n = 0;
    while ((exp_w.size() + wq.size()) != 0 && n < 300) begin @(negedge clk); n++; end
    chk("w_idle_wait", exp_w.size() + wq.size(), 0);
    exp_w.delete(); wq.delete();
    @(negedge clk);
  endtask

  task automatic wait_r_idle();
    int n = 0;
    while ((exp_r.size() + rq.size()) != 0 && n < 300) begin @(negedge clk); n++; end
    chk("r_idle_wait", exp_r.size() + rq.size(), 0);
    exp_r.delete(); rq.delete();
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valids"}, {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk({tag, "_acks"}, {28'd0, up_wack, up_werr, up_rack, up_rerr}, 0);
    chk({tag, "_rdata"}, up_rdata, 0);
    chk({tag, "_addrs"}, {8'd0, m_axi_awaddr, m_axi_araddr}, 0);
  endtask

  // Write-side slave: per-transaction ready waits and B delay, plus AXI checks.
  initial begin : w_slave
    wcfg_t c;
    int awc, wc, bc;
    bit act, awd, wd, aw_pend, w_pend, b_hs, aw_hs, w_hs;
    act = 0; awd = 0; wd = 0; aw_pend = 0; w_pend = 0; b_hs = 0; awc = 0; wc = 0; bc = 0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        act = 0; awd = 0; wd = 0; aw_pend = 0; w_pend = 0; b_hs = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        wq.delete();
        continue;
      end
      if (aw_pend) chk("aw_hold", m_axi_awvalid, 1);
      if (w_pend)  chk("w_hold", m_axi_wvalid, 1);
      if (act && awd) chk("aw_drop", m_axi_awvalid, 0);
      if (act && wd)  chk("w_drop", m_axi_wvalid, 0);
      if (b_hs) begin
        m_axi_bvalid = 0; c = wq.pop_front(); act = 0; b_hs = 0;
      end
      if (act && awd && wd && !m_axi_bvalid) begin
        if (bc == 0) begin m_axi_bvalid = 1; m_axi_bresp = c.resp; end
        else bc--;
      end
      b_hs = m_axi_bvalid && m_axi_bready;
      if (!act && (m_axi_awvalid || m_axi_wvalid)) begin
        if (wq.size() == 0) chk("w_unexpected_valid", {31'd0, m_axi_awvalid | m_axi_wvalid}, 0);
        else begin
          c = wq[0]; act = 1; awd = 0; wd = 0;
          awc = c.aw_wait; wc = c.w_wait; bc = c.b_delay;
        end
      end
      m_axi_awready = 0; m_axi_wready = 0; aw_hs = 0; w_hs = 0;
      if (act && !awd && m_axi_awvalid) begin
        if (awc == 0) begin
          m_axi_awready = 1; aw_hs = 1; awd = 1;
          chk("awaddr", m_axi_awaddr, 12'(c.addr * 4));
          chk("awprot", m_axi_awprot, 0);
        end else awc--;
      end
      if (act && !wd && m_axi_wvalid) begin
        if (wc == 0) begin
          m_axi_wready = 1; w_hs = 1; wd = 1;
          chk("wdata", m_axi_wdata, c.data);
          chk("wstrb", m_axi_wstrb, 4'hF);
        end else wc--;
      end
      aw_pend = m_axi_awvalid && !aw_hs;
      w_pend  = m_axi_wvalid && !w_hs;
    end
  end

  initial begin : r_slave
    rcfg_t c;
    int arc, rc;
    bit act, ard, ar_pend, r_hs, ar_hs;
    act = 0; ard = 0; ar_pend = 0; r_hs = 0; arc = 0; rc = 0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        act = 0; ard = 0; ar_pend = 0; r_hs = 0;
        m_axi_arready = 0; m_axi_rvalid = 0;
        rq.delete();
        continue;
      end
      if (ar_pend) chk("ar_hold", m_axi_arvalid, 1);
      if (act && ard) chk("ar_drop", m_axi_arvalid, 0);
      if (r_hs) begin
        m_axi_rvalid = 0; c = rq.pop_front(); act = 0; r_hs = 0;
      end
      if (act && ard && !m_axi_rvalid) begin
        if (rc == 0) begin m_axi_rvalid = 1; m_axi_rdata = c.data; m_axi_rresp = c.resp; end
        else rc--;
      end
      r_hs = m_axi_rvalid && m_axi_rready;
      if (!act && m_axi_arvalid) begin
        if (rq.size() == 0) chk("r_unexpected_valid", {31'd0, m_axi_arvalid}, 0);
        else begin
          c = rq[0]; act = 1; ard = 0; arc = c.ar_wait; rc = c.r_delay;
        end
      end
      m_axi_arready = 0; ar_hs = 0;
      if (act && !ard && m_axi_arvalid) begin
        if (arc == 0) begin
          m_axi_arready = 1; ar_hs = 1; ard = 1;
          chk("araddr", m_axi_araddr, 12'(c.addr * 4));
          chk("arprot", m_axi_arprot, 0);
        end else arc--;
      end
      ar_pend = m_axi_arvalid && !ar_hs;
    end
  end

  initial begin : monitor
    exp_t e;
    logic [31:0] hold;
    hold = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin hold = 32'h0; continue; end
      if (up_wack) begin
        if (exp_w.size() == 0) chk("wack_unexpected", {31'd0, up_wack}, 0);
        else begin
          e = exp_w.pop_front();
          chk("werr", {31'd0, up_werr}, {31'd0, e.err});
          chk("wack_cycle", cyc, e.cyc);
        end
      end
      if (up_rack) begin
        if (exp_r.size() == 0) chk("rack_unexpected", {31'd0, up_rack}, 0);
        else begin
          e = exp_r.pop_front();
          chk("rdata", up_rdata, e.data);
          chk("rerr", {31'd0, up_rerr}, {31'd0, e.err});
          chk("rack_cycle", cyc, e.cyc);
          hold = e.data;
        end
      end else begin
        chk("rdata_hold", up_rdata, hold);
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    do_write(10'h005, 32'h1234_5678, 0, 0, 0, 2'b00);
    wait_w_idle();
    do_write(10'h2A1, 32'hA5A5_0F0F, 2, 0, 0, 2'b10);
    wait_w_idle();
    do_read(10'h3FF, 32'hCAFE_F00D, 0, 5, 2'b00);
    wait_r_idle();
    repeat (3) @(negedge clk);

    // Response never arrives in time; the late one must be drained silently.
    do_read(10'h077, 32'h1111_2222, 0, TMO + 10, 2'b00);
    n = 0;
    while (exp_r.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("tmo_rack_seen", exp_r.size(), 0);
    repeat (2) @(negedge clk);
    up_raddr = 10'h123; up_rreq = 1'b1;
    @(negedge clk);
    up_rreq = 1'b0;
    chk("drain_rreq_ignored", {31'd0, m_axi_arvalid}, 0);
    wait_r_idle();
    chk("drain_done_no_ar", {31'd0, m_axi_arvalid}, 0);

    fork
      do_write(10'h155, 32'h0BAD_F00D, 1, 0, 2, 2'b01);
      do_read(10'h2AA, 32'h7654_3210, 0, 1, 2'b11);
    join
    chk("simul_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b111);
    wait_w_idle();
    wait_r_idle();

    do_read(10'h0F0, 32'h9999_8888, 0, 1000, 2'b00);
    n = 0;
    while (!m_axi_rready && n < 50) begin @(negedge clk); n++; end
    chk("rst_in_resp", {31'd0, m_axi_rready}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    rst = 1'b0;
    exp_r.delete();
    @(negedge clk);
    do_read(10'h0AB, 32'h5555_AAAA, 1, 2, 2'b01);
    wait_r_idle();
    do_write(10'h0CD, 32'h0102_0304, 0, 1, 1, 2'b11);
    wait_w_idle();

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_write(10'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4), 2'($urandom_range(0, 3)));
          wait_w_idle();
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          do_read(10'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 4),
                  2'($urandom_range(0, 3)));
          wait_r_idle();
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=%0d cycles required=completion", cyc);
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire

// File: doc/up_axi_master.md
Name: up_axi_master

Overview:
- AXI4-Lite initiator: converts the codebase's single-word up_* register request interface (wreq/rreq, word address, ack) into AXI4-Lite master transactions.
- Initiator counterpart of the existing up_axi responder bridge.
- Lets fabric-side logic (sequencers, self-test, the trigger subsystem's host-less mode) program AXI-Lite register banks such as axi_ts_regs.
- Independent write and read engines, one outstanding transaction each, optional response timeout.

Parameters:
- AXI_ADDR_WIDTH, 12, byte address width of m_axi_awaddr/araddr; up_* addresses are AXI_ADDR_WIDTH-2 wide (word addresses).
- TIMEOUT_CYCLES, 1024, cycles to wait for B/R response before forcing an error ack; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- up_wreq  in  1  single-cycle write request pulse.
- up_waddr  in  AXI_ADDR_WIDTH-2  word write address.
- up_wdata  in  32  write data.
- up_wack  out  1  single-cycle write done pulse.
- up_werr  out  1  valid with up_wack; 1 = SLVERR/DECERR/timeout.
- up_rreq  in  1  single-cycle read request pulse.
- up_raddr  in  AXI_ADDR_WIDTH-2  word read address.
- up_rdata  out  32  read data, valid with up_rack, held until the next rack.
- up_rack  out  1  single-cycle read done pulse.
- up_rerr  out  1  valid with up_rack.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  AXI_ADDR_WIDTH/3/1/1  AW channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  AXI_ADDR_WIDTH/3/1/1  AR channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All valid/ready outputs, up_wack, up_rack, up_werr, up_rerr = 0.
  - up_rdata = 0.
  - Address outputs = 0.
  - Both FSMs go to IDLE and the timeout counters clear.
  - Reset mid-transaction abandons it with no ack.
- Address mapping: awaddr/araddr = {up_addr, 2'b00}; awprot = arprot = 3'b000; wstrb = 4'hF.
- Write FSM states: IDLE, ADDR, RESP, DRAIN.
  - IDLE: on up_wreq, register addr/data; next cycle awvalid = wvalid = 1 (ADDR). Request is accepted only in IDLE; up_wreq in any other state is ignored.
  - ADDR: awvalid drops the cycle after awvalid&awready; wvalid drops after wvalid&wready. The two handshakes are independent and may complete in either order or together. Valids never drop before their handshake. Go to RESP once both are done.
  - RESP: bready = 1. On bvalid: up_wack = 1 and up_werr = bresp[1] the next cycle, then IDLE.
  - Minimum latency: up_wreq to up_wack is 3 cycles with a zero-wait slave (AW/W accept on first valid cycle, B the following cycle).
  - Timeout: counter runs only in RESP. When it reaches TIMEOUT_CYCLES, pulse up_wack with up_werr = 1 and go to DRAIN.
  - DRAIN: bready = 1 until bvalid, then IDLE. No ack is issued for the drained response.
- Read FSM states: IDLE, ADDR, RESP, DRAIN.
  - Same rules, with AR in place of AW/W and rready in RESP/DRAIN.
  - On rvalid: up_rdata = m_axi_rdata, up_rerr = rresp[1], up_rack = 1.
  - On timeout: up_rdata = 32'hDEAD_DEAD, up_rerr = 1.
  - Minimum latency: 3 cycles.
- Simultaneous up_wreq and up_rreq: both engines proceed in parallel, with no ordering between them.
- EXOKAY (2'b01) is treated as OKAY.
- The address phase has no timeout; AXI valid-stability rules take precedence.

Decomposition:
- Package up_axi_master_pkg holds:
  - chan_state_t enum {IDLE, ADDR, RESP, DRAIN}.
  - AXI response constants RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - TIMEOUT_RDATA = 32'hDEAD_DEAD.
- One sub-module, up_axi_master_tmo: clear/enable timeout counter with a terminal pulse, instantiated once per engine and tied off when TIMEOUT_CYCLES = 0.

Test Plan:
- Zero-wait slave: write addr 0x005, data 0x1234_5678 -> awaddr 0x014, wdata 0x1234_5678, wstrb 0xF; up_wack 3 cycles after up_wreq, up_werr 0.
- Slave asserts wready 2 cycles before awready, then bvalid with bresp 2'b10 -> awvalid held until accepted, wvalid dropped after its handshake; up_wack with up_werr 1.
- Read addr 0x3FF, slave returns rdata 0xCAFE_F00D after 5 wait cycles -> araddr 0xFFC; up_rdata 0xCAFE_F00D with up_rack, up_rerr 0; up_rdata held afterwards.
- TIMEOUT_CYCLES = 16, slave never sends R -> up_rack exactly 16 cycles into RESP, up_rdata 0xDEAD_DEAD, up_rerr 1. Late rvalid 10 cycles later is drained with no second rack. An up_rreq issued during DRAIN is ignored.
- up_wreq and up_rreq in the same cycle -> AW/W and AR all asserted the next cycle; both acks occur, each independently.
- rst asserted while in RESP -> all outputs 0 next cycle, no ack; a new request after reset completes normally.
